// File: rtl/drop_pkg.sv
// Shared types and constants for the falling-block generator.
package drop_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      OVER
   } drop_state_t;

   localparam int unsigned NUM_SLOTS        = 6;
   localparam int unsigned POS_W            = 10;
   localparam int unsigned LANE_W           = 2;
   localparam int unsigned DEFAULT_SCREEN_H = 480;

   // Out-of-range raw lane values fold back into the valid range.
   function automatic logic [LANE_W-1:0] map_lane(input logic [LANE_W-1:0] raw,
                                                 input int unsigned       lanes);
      if (32'(raw) >= lanes)
         return LANE_W'(32'(raw) - lanes);
      else
         return raw;
   endfunction

endpackage

// File: rtl/drop_blocks_if.sv
// Game-side bus of drop_blocks: scene/tick/hit in, block field and score out.
interface drop_blocks_if;
   import drop_pkg::*;

   logic [1:0]                  scene;
   logic                        tick;
   logic                        hit;
   logic [NUM_SLOTS*POS_W-1:0]  pos_blocks;
   logic [NUM_SLOTS*LANE_W-1:0] blocks;
   logic [15:0]                 score;
   logic                        game_over;

   modport master (
      output scene, tick, hit,
      input  pos_blocks, blocks, score, game_over
   );

   modport slave (
      input  scene, tick, hit,
      output pos_blocks, blocks, score, game_over
   );

endinterface

// File: rtl/drop_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16/14/13/11), free-running; exposes the low lane bits.
module drop_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] value
);

   logic [15:0] state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= SEED;
      else
         state_q <= {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
   end

   assign value = state_q[1:0];

endmodule

// File: rtl/drop_blocks.sv
// Falling-block generator: six slots advanced per frame tick, retired at the
// bottom edge for score, respawned into pseudo-random lanes; frozen on hit.
module drop_blocks
   import drop_pkg::*;
#(
   parameter int unsigned SPEED     = 4,
   parameter int unsigned SPAWN_GAP = 20,
   parameter int unsigned SCREEN_H  = DEFAULT_SCREEN_H,
   parameter int unsigned LANES     = 3,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input logic          clk,
   input logic          rst_n,
   drop_blocks_if.slave bus
);

   localparam int unsigned      CNT_W    = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_GAP - 1);
   localparam logic [POS_W:0]   STEP     = (POS_W + 1)'(SPEED);
   localparam logic [POS_W:0]   EXIT_Y   = (POS_W + 1)'(SCREEN_H);
   localparam int unsigned      RET_W    = $clog2(NUM_SLOTS + 1);

   drop_state_t state_q, state_d;
   logic        clear_field;
   logic        clear_run;
   logic        step;

   logic [1:0]       lfsr_bits;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      score_q;
   logic             game_over_q;

   logic              active_q [NUM_SLOTS];
   logic [POS_W-1:0]  pos_q    [NUM_SLOTS];
   logic [LANE_W-1:0] lane_q   [NUM_SLOTS];
   logic [POS_W:0]    next_pos [NUM_SLOTS];

   logic [NUM_SLOTS-1:0] retire;
   logic [NUM_SLOTS-1:0] spawn_sel;
   logic                 any_free;
   logic                 spawn_due;
   logic [RET_W-1:0]     retire_cnt;
   logic [16:0]          score_sum;
   logic [LANE_W-1:0]    spawn_lane;
   logic                 unused_scene;

   assign unused_scene = bus.scene[1];

   drop_lfsr #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .value (lfsr_bits)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      clear_field = 1'b0;
      clear_run   = 1'b0;
      step        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.scene[0]) begin
               state_d     = RUN;
               clear_field = 1'b1;
               clear_run   = 1'b1;
            end
         end
         RUN: begin
            if (!bus.scene[0]) begin
               state_d     = IDLE;
               clear_field = 1'b1;
            end else if (bus.hit) begin
               state_d = OVER;
            end else begin
               step = bus.tick;
            end
         end
         OVER: begin
            if (!bus.scene[0]) begin
               state_d     = IDLE;
               clear_field = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Spawn target is chosen from the pre-move occupancy, so a slot retired
   // on this tick only becomes eligible on the following one.
   always_comb begin
      spawn_sel  = '0;
      any_free   = 1'b0;
      retire     = '0;
      retire_cnt = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         next_pos[i] = {1'b0, pos_q[i]} + STEP;
         retire[i]   = active_q[i] && (next_pos[i] >= EXIT_Y);
         retire_cnt  = retire_cnt + RET_W'(retire[i]);
         if (!active_q[i] && !any_free) begin
            spawn_sel[i] = spawn_due;
            any_free     = 1'b1;
         end
      end
   end

   assign spawn_due  = (cnt_q == CNT_LAST);
   assign spawn_lane = map_lane(lfsr_bits, LANES);
   assign score_sum  = {1'b0, score_q} + 17'(retire_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         score_q     <= '0;
         game_over_q <= 1'b0;
      end else begin
         game_over_q <= (state_d == OVER);
         if (clear_run) begin
            cnt_q   <= '0;
            score_q <= '0;
         end else if (step) begin
            score_q <= score_sum[16] ? '1 : score_sum[15:0];
            if (!spawn_due)
               cnt_q <= cnt_q + 1'b1;
            else if (any_free)
               cnt_q <= '0;
         end
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            active_q[g] <= 1'b0;
            pos_q[g]    <= '0;
            lane_q[g]   <= '0;
         end else if (clear_field) begin
            active_q[g] <= 1'b0;
            pos_q[g]    <= '0;
            lane_q[g]   <= '0;
         end else if (step) begin
            if (spawn_sel[g]) begin
               active_q[g] <= 1'b1;
               pos_q[g]    <= '0;
               lane_q[g]   <= spawn_lane;
            end else if (retire[g]) begin
               active_q[g] <= 1'b0;
               pos_q[g]    <= '0;
               lane_q[g]   <= '0;
            end else if (active_q[g]) begin
               pos_q[g] <= next_pos[g][POS_W-1:0];
            end
         end
      end

      assign bus.pos_blocks[POS_W*g +: POS_W]                 = pos_q[g];
      assign bus.blocks[LANE_W*(NUM_SLOTS-1-g) +: LANE_W] = lane_q[g];
   end

   assign bus.score     = score_q;
   assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_drop_blocks.sv
// Directed bench for drop_blocks: default build plus a SPEED=1/SPAWN_GAP=1 build.
module tb_drop_blocks;
   import drop_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   drop_blocks_if bus_a ();
   drop_blocks_if bus_b ();

   drop_blocks #(
      .SPEED     (4),
      .SPAWN_GAP (20),
      .SCREEN_H  (480),
      .LANES     (3),
      .SEED      (16'hACE1)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   drop_blocks #(
      .SPEED     (1),
      .SPAWN_GAP (1),
      .SCREEN_H  (480),
      .LANES     (3),
      .SEED      (16'hACE1)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   int checks   = 0;
   int failures = 0;

   // Reference LFSR, used to predict the lane of a spawn.
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         m_lfsr <= 16'hACE1;
      else
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   logic [15:0] last_lfsr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick_a(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus_a.tick = 1'b1;
         last_lfsr  = m_lfsr;
         @(posedge clk);
         #1 bus_a.tick = 1'b0;
      end
   endtask

   task automatic tick_b(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus_b.tick = 1'b1;
         @(posedge clk);
         #1 bus_b.tick = 1'b0;
      end
   endtask

   function automatic logic [1:0] exp_lane(input logic [15:0] l);
      logic [1:0] v;
      v = l[1:0];
      return (v == 2'd3) ? 2'd0 : v;
   endfunction

   logic [1:0]  lane_first;
   logic [1:0]  lane_replay;
   logic [59:0] exp_pos;
   logic [1:0]  lane_v;

   initial begin
      bus_a.scene = 2'b00; bus_a.tick = 1'b0; bus_a.hit = 1'b0;
      bus_b.scene = 2'b00; bus_b.tick = 1'b0; bus_b.hit = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_pos",       64'(bus_a.pos_blocks), 64'd0);
      check("reset_blocks",    64'(bus_a.blocks),     64'd0);
      check("reset_score",     64'(bus_a.score),      64'd0);
      check("reset_game_over", 64'(bus_a.game_over), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // Basic spawn and move
      @(negedge clk) bus_a.scene = 2'b01;
      @(negedge clk);
      tick_a(19);
      check("no_spawn_before_gap_lane", 64'(bus_a.blocks), 64'd0);
      tick_a(1);
      lane_first = bus_a.blocks[11:10];
      check("first_spawn_pos",  64'(bus_a.pos_blocks[9:0]), 64'd0);
      check("first_spawn_lane", 64'(lane_first), 64'(exp_lane(last_lfsr)));
      check("first_lane_range", 64'(lane_first < 2'd3), 64'd1);
      tick_a(1);
      check("slot0_after_1", 64'(bus_a.pos_blocks[9:0]), 64'd4);
      tick_a(9);
      check("slot0_after_10", 64'(bus_a.pos_blocks[9:0]), 64'd40);

      // Retirement at the bottom edge (tick 140) and deferred respawn
      tick_a(109);
      check("slot0_at_476", 64'(bus_a.pos_blocks[9:0]), 64'd476);
      check("score_pre_ret", 64'(bus_a.score), 64'd0);
      tick_a(1);
      check("slot0_retired_pos",  64'(bus_a.pos_blocks[9:0]),   64'd0);
      check("slot0_retired_lane", 64'(bus_a.blocks[11:10]),     64'd0);
      check("score_after_ret",    64'(bus_a.score),             64'd1);
      check("slot1_at_400",       64'(bus_a.pos_blocks[19:10]), 64'd400);
      tick_a(2);
      check("slot0_respawn_moved", 64'(bus_a.pos_blocks[9:0]),  64'd4);
      check("slot5_pos",           64'(bus_a.pos_blocks[59:50]), 64'd88);

      // Advance to tick 261: seven retirements
      tick_a(119);
      check("score_7", 64'(bus_a.score), 64'd7);
      exp_pos = {10'd80, 10'd160, 10'd240, 10'd320, 10'd400, 10'd0};
      check("field_t261", 64'(bus_a.pos_blocks), 64'(exp_pos));

      // Hit together with tick
      @(negedge clk);
      bus_a.tick = 1'b1;
      bus_a.hit  = 1'b1;
      @(posedge clk);
      #1;
      bus_a.tick = 1'b0;
      bus_a.hit  = 1'b0;
      check("hit_game_over", 64'(bus_a.game_over),  64'd1);
      check("hit_field",     64'(bus_a.pos_blocks), 64'(exp_pos));
      check("hit_score",     64'(bus_a.score),      64'd7);
      tick_a(3);
      check("over_field_frozen", 64'(bus_a.pos_blocks), 64'(exp_pos));
      check("over_score_frozen", 64'(bus_a.score),      64'd7);
      check("over_game_over",    64'(bus_a.game_over),  64'd1);

      // Scene exit and restart
      @(negedge clk) bus_a.scene = 2'b00;
      @(posedge clk);
      #1;
      check("exit_pos",       64'(bus_a.pos_blocks), 64'd0);
      check("exit_blocks",    64'(bus_a.blocks),     64'd0);
      check("exit_score",     64'(bus_a.score),      64'd7);
      check("exit_game_over", 64'(bus_a.game_over),  64'd0);
      @(negedge clk) bus_a.scene = 2'b01;
      @(posedge clk);
      #1;
      check("restart_score",     64'(bus_a.score),     64'd0);
      check("restart_game_over", 64'(bus_a.game_over), 64'd0);

      // Asynchronous reset mid-RUN
      tick_a(25);
      check("pre_reset_slot0", 64'(bus_a.pos_blocks[9:0]), 64'd20);
      @(posedge clk);
      #3;
      rst_n       = 1'b0;
      bus_a.scene = 2'b00;
      #1;
      check("async_rst_pos",    64'(bus_a.pos_blocks), 64'd0);
      check("async_rst_blocks", 64'(bus_a.blocks),     64'd0);
      check("async_rst_score",  64'(bus_a.score),      64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) bus_a.scene = 2'b01;
      @(negedge clk);
      tick_a(20);
      lane_replay = bus_a.blocks[11:10];
      check("replay_lane_same",  64'(lane_replay), 64'(lane_first));
      check("replay_lane_model", 64'(lane_replay), 64'(exp_lane(last_lfsr)));

      // Field full with SPEED=1, SPAWN_GAP=1
      @(negedge clk) bus_b.scene = 2'b01;
      @(negedge clk);
      tick_b(6);
      exp_pos = {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
      check("full_field_6", 64'(bus_b.pos_blocks), 64'(exp_pos));
      for (int i = 0; i < 6; i++) begin
         lane_v = bus_b.blocks[2*i +: 2];
         check($sformatf("full_lane_range_%0d", i), 64'(lane_v < 2'd3), 64'd1);
      end
      tick_b(1);
      exp_pos = {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
      check("full_field_7", 64'(bus_b.pos_blocks), 64'(exp_pos));
      tick_b(1);
      exp_pos = {10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
      check("full_field_8", 64'(bus_b.pos_blocks), 64'(exp_pos));
      check("full_score",   64'(bus_b.score), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
